// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: computes the 16 round subkeys one per clock into an
// internal array and serves them through a combinational read port in either round order.
module des_key_schedule (
   input  logic        clk,
   input  logic        reset,
   input  logic        key_we_hi,
   input  logic        key_we_lo,
   input  logic [31:0] wdata,
   input  logic        start,
   input  logic        mode,
   input  logic [3:0]  sk_idx,
   output logic [47:0] subkey,
   output logic        busy,
   output logic        ready
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND} state_t;

   // Tables hold DES bit numbers (bit 1 = MSB of the source vector).
   localparam int PC1 [56] = '{57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,
                               10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
                               63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                               14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
   localparam int PC2 [48] = '{14,17,11,24, 1, 5, 3,28,15, 6,21,10,
                               23,19,12, 4,26, 8,16, 7,27,20,13, 2,
                               41,52,31,37,47,55,30,40,51,45,33,48,
                               44,49,39,56,34,53,46,42,50,36,29,32};

   function automatic logic [55:0] f_pc1(input logic [63:0] key);
      logic [55:0] v;
      v = '0;
      for (int i = 0; i < 56; i++) v[55-i] = key[64-PC1[i]];
      return v;
   endfunction

   function automatic logic [47:0] f_pc2(input logic [55:0] cd);
      logic [47:0] v;
      v = '0;
      for (int i = 0; i < 48; i++) v[47-i] = cd[56-PC2[i]];
      return v;
   endfunction

   function automatic logic [27:0] f_rotl(input logic [27:0] x, input logic two);
      return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
   endfunction

   state_t      r_state;
   logic [63:0] r_key;
   logic [27:0] r_c, r_d;
   logic [3:0]  r_rnd;
   logic        r_mode;
   logic        r_ready;
   logic [47:0] r_sk [16];

   logic        w_kw;
   logic        w_two;
   logic [55:0] w_pc1;
   logic [27:0] w_c_rot, w_d_rot;
   logic [47:0] w_pc2;
   logic [3:0]  w_rd_idx;

   assign w_kw    = key_we_hi | key_we_lo;
   assign w_two   = !(r_rnd == 4'd0 || r_rnd == 4'd1 || r_rnd == 4'd8 || r_rnd == 4'd15);
   assign w_pc1   = f_pc1(r_key);
   assign w_c_rot = f_rotl(r_c, w_two);
   assign w_d_rot = f_rotl(r_d, w_two);
   assign w_pc2   = f_pc2({w_c_rot, w_d_rot});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_key <= '0;
      end else begin
         if (key_we_hi) r_key[63:32] <= wdata;
         if (key_we_lo) r_key[31:0]  <= wdata;
      end
   end

   // A key write outside IDLE aborts; in IDLE it only invalidates the stored schedule.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_ready <= 1'b0;
         r_mode  <= 1'b0;
         r_c     <= '0;
         r_d     <= '0;
         r_rnd   <= '0;
         for (int i = 0; i < 16; i++) r_sk[i] <= '0;
      end else if (w_kw && r_state != S_IDLE) begin
         r_state <= S_IDLE;
         r_ready <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mode  <= mode;
                  r_ready <= 1'b0;
                  r_state <= S_LOAD;
               end else if (w_kw) begin
                  r_ready <= 1'b0;
               end
            end
            S_LOAD: begin
               r_c     <= w_pc1[55:28];
               r_d     <= w_pc1[27:0];
               r_rnd   <= '0;
               r_state <= S_ROUND;
            end
            S_ROUND: begin
               r_c         <= w_c_rot;
               r_d         <= w_d_rot;
               r_sk[r_rnd] <= w_pc2;
               if (r_rnd == 4'd15) begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
               end else begin
                  r_rnd <= r_rnd + 4'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_rd_idx = r_mode ? (4'd15 - sk_idx) : sk_idx;
   assign subkey   = r_sk[w_rd_idx];
   assign busy     = (r_state != S_IDLE);
   assign ready    = r_ready;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic 133457799BBCDFF1 key vectors.
`timescale 1ns/1ps
module tb_des_key_schedule;

   logic        clk = 1'b0;
   logic        reset;
   logic        key_we_hi, key_we_lo;
   logic [31:0] wdata;
   logic        start, mode;
   logic [3:0]  sk_idx;
   logic [47:0] subkey;
   logic        busy, ready;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [47:0] K1  = 48'h1B02EFFC7072;
   localparam logic [47:0] K2  = 48'h79AED9DBC9E5;
   localparam logic [47:0] K16 = 48'hCB3D8B0E17F5;

   des_key_schedule dut (
      .clk(clk), .reset(reset), .key_we_hi(key_we_hi), .key_we_lo(key_we_lo),
      .wdata(wdata), .start(start), .mode(mode), .sk_idx(sk_idx),
      .subkey(subkey), .busy(busy), .ready(ready)
   );

   always #20 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_hi(input logic [31:0] d);
      key_we_hi = 1'b1; wdata = d; tick(); key_we_hi = 1'b0;
   endtask

   task automatic write_lo(input logic [31:0] d);
      key_we_lo = 1'b1; wdata = d; tick(); key_we_lo = 1'b0;
   endtask

   task automatic pulse_start(input logic m);
      start = 1'b1; mode = m; tick(); start = 1'b0;
   endtask

   task automatic wait_busy(output int cnt);
      cnt = 0;
      while (busy && cnt < 100) begin
         cnt++;
         tick();
      end
   endtask

   task automatic test_reset();
      write_hi(32'h13345779);
      write_lo(32'h9BBCDFF1);
      pulse_start(1'b0);
      repeat (5) tick();
      sk_idx = 4'd0; #1;
      n_checks++;
      if (subkey !== K1) begin n_fail++; $display("FAIL rst_pre_sk0 got=%h exp=%h", subkey, K1); end
      reset = 1'b1; #1;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
      n_checks++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", ready); end
      for (int i = 0; i < 16; i++) begin
         sk_idx = 4'(i); #1;
         n_checks++;
         if (subkey !== 48'h0) begin n_fail++; $display("FAIL rst_sk%0d got=%h exp=0", i, subkey); end
      end
      tick();
      reset = 1'b0;
      repeat (3) tick();
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_encrypt();
      int cnt;
      write_hi(32'h13345779);
      write_lo(32'h9BBCDFF1);
      pulse_start(1'b0);
      wait_busy(cnt);
      n_checks++;
      if (cnt !== 17) begin n_fail++; $display("FAIL enc_busy_cycles got=%0d exp=17", cnt); end
      n_checks++;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL enc_ready got=%b exp=1", ready); end
      sk_idx = 4'd0; #1;
      n_checks++;
      if (subkey !== K1) begin n_fail++; $display("FAIL enc_sk0 got=%h exp=%h", subkey, K1); end
      sk_idx = 4'd1; #1;
      n_checks++;
      if (subkey !== K2) begin n_fail++; $display("FAIL enc_sk1 got=%h exp=%h", subkey, K2); end
      sk_idx = 4'd15; #1;
      n_checks++;
      if (subkey !== K16) begin n_fail++; $display("FAIL enc_sk15 got=%h exp=%h", subkey, K16); end
   endtask

   task automatic test_decrypt();
      int cnt;
      mode = 1'b1; sk_idx = 4'd0; #1;
      n_checks++;
      if (subkey !== K1) begin n_fail++; $display("FAIL dec_premode_sk0 got=%h exp=%h", subkey, K1); end
      pulse_start(1'b1);
      n_checks++;
      if (subkey !== K16) begin n_fail++; $display("FAIL dec_latched_sk0 got=%h exp=%h", subkey, K16); end
      wait_busy(cnt);
      n_checks++;
      if (cnt !== 17) begin n_fail++; $display("FAIL dec_busy_cycles got=%0d exp=17", cnt); end
      sk_idx = 4'd0; #1;
      n_checks++;
      if (subkey !== K16) begin n_fail++; $display("FAIL dec_sk0 got=%h exp=%h", subkey, K16); end
      sk_idx = 4'd14; #1;
      n_checks++;
      if (subkey !== K2) begin n_fail++; $display("FAIL dec_sk14 got=%h exp=%h", subkey, K2); end
      sk_idx = 4'd15; #1;
      n_checks++;
      if (subkey !== K1) begin n_fail++; $display("FAIL dec_sk15 got=%h exp=%h", subkey, K1); end
   endtask

   task automatic test_abort();
      int cnt;
      write_lo(32'h00000000);
      n_checks++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL abort_kw_clears_ready got=%b exp=0", ready); end
      pulse_start(1'b0);
      repeat (7) tick();
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy got=%b exp=1", busy); end
      write_lo(32'h9BBCDFF1);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
      n_checks++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready got=%b exp=0", ready); end
      pulse_start(1'b0);
      wait_busy(cnt);
      n_checks++;
      if (cnt !== 17) begin n_fail++; $display("FAIL abort_rerun_cycles got=%0d exp=17", cnt); end
      sk_idx = 4'd0; #1;
      n_checks++;
      if (subkey !== K1) begin n_fail++; $display("FAIL abort_sk0 got=%h exp=%h", subkey, K1); end
      sk_idx = 4'd15; #1;
      n_checks++;
      if (subkey !== K16) begin n_fail++; $display("FAIL abort_sk15 got=%h exp=%h", subkey, K16); end
   endtask

   task automatic test_ignored_start();
      pulse_start(1'b0);
      repeat (2) tick();
      pulse_start(1'b1);
      repeat (6) tick();
      pulse_start(1'b1);
      repeat (6) tick();
      n_checks++;
      if (busy !== 1'b1 || ready !== 1'b0)
         begin n_fail++; $display("FAIL ign_n16 got=busy%b/ready%b exp=busy1/ready0", busy, ready); end
      tick();
      n_checks++;
      if (busy !== 1'b0 || ready !== 1'b1)
         begin n_fail++; $display("FAIL ign_n17 got=busy%b/ready%b exp=busy0/ready1", busy, ready); end
      repeat (3) tick();
      n_checks++;
      if (busy !== 1'b0 || ready !== 1'b1)
         begin n_fail++; $display("FAIL ign_no_rerun got=busy%b/ready%b exp=busy0/ready1", busy, ready); end
      sk_idx = 4'd0; #1;
      n_checks++;
      if (subkey !== K1) begin n_fail++; $display("FAIL ign_mode_kept got=%h exp=%h", subkey, K1); end
   endtask

   task automatic test_same_cycle();
      int cnt;
      reset = 1'b1; tick(); reset = 1'b0; tick();
      write_hi(32'h13345779);
      key_we_lo = 1'b1; wdata = 32'h9BBCDFF1; start = 1'b1; mode = 1'b0;
      tick();
      key_we_lo = 1'b0; start = 1'b0;
      wait_busy(cnt);
      n_checks++;
      if (cnt !== 17) begin n_fail++; $display("FAIL same_cycles got=%0d exp=17", cnt); end
      sk_idx = 4'd0; #1;
      n_checks++;
      if (subkey !== K1) begin n_fail++; $display("FAIL same_sk0 got=%h exp=%h", subkey, K1); end
      write_lo(32'h9BBCDFF0);
      n_checks++;
      if (ready !== 1'b0) begin n_fail++; $display("FAIL parity_kw_ready got=%b exp=0", ready); end
      pulse_start(1'b0);
      wait_busy(cnt);
      n_checks++;
      if (ready !== 1'b1) begin n_fail++; $display("FAIL parity_ready got=%b exp=1", ready); end
      sk_idx = 4'd0; #1;
      n_checks++;
      if (subkey !== K1) begin n_fail++; $display("FAIL parity_sk0 got=%h exp=%h", subkey, K1); end
      sk_idx = 4'd1; #1;
      n_checks++;
      if (subkey !== K2) begin n_fail++; $display("FAIL parity_sk1 got=%h exp=%h", subkey, K2); end
      sk_idx = 4'd15; #1;
      n_checks++;
      if (subkey !== K16) begin n_fail++; $display("FAIL parity_sk15 got=%h exp=%h", subkey, K16); end
   endtask

   initial begin
      reset = 1'b1; key_we_hi = 1'b0; key_we_lo = 1'b0; wdata = '0;
      start = 1'b0; mode = 1'b0; sk_idx = '0;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      test_reset();
      test_encrypt();
      test_decrypt();
      test_abort();
      test_ignored_start();
      test_same_cycle();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Iterative DES key-schedule generator sitting directly upstream of the DES round datapath. Accepts a 64-bit key as two 32-bit memory-mapped writes from the address-decoder write strobes and, on a start pulse, computes the 16 48-bit round subkeys at one per clock. It stores them in an internal 16-entry array and serves them through a combinational indexed read port in encrypt or decrypt order.

## Interface
Parameters: none; all widths are fixed by DES.

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- key_we_hi  in  1  write strobe, loads wdata into key_reg[63:32]
- key_we_lo  in  1  write strobe, loads wdata into key_reg[31:0]
- wdata  in  32  bus write data (writedataM)
- start  in  1  single-cycle request to generate the schedule
- mode  in  1  0 = encrypt order, 1 = decrypt order; sampled with start
- sk_idx  in  4  round index being read (0 = first round applied)
- subkey  out  48  subkey for round sk_idx in the latched order
- busy  out  1  generation in progress
- ready  out  1  array holds a complete schedule for the current key_reg

## Operation
- Bit numbering: DES bit 1 is key_reg[63]; subkey bit 1 is subkey[47]. Parity bits (DES 8,16,…,64) are ignored.
- FSM states:
  - IDLE: if start=1, latch mode into mode_q, clear ready, go to LOAD. Otherwise stay.
  - LOAD: C <= PC-1 left half (28b), D <= PC-1 right half (28b), rnd <= 0, go to ROUND.
  - ROUND: rotate C and D left by shift[rnd], with shift = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Write PC-2 of the rotated {C,D} into sk[rnd]. When rnd=15, go to IDLE and set ready=1. Otherwise rnd <= rnd+1.
- busy = (state != IDLE).
- Read port (combinational): subkey = mode_q ? sk[15-sk_idx] : sk[sk_idx].
- Key writes:
  - Accepted in any state.
  - Any key write clears ready.
  - A key write while busy aborts the run: state becomes IDLE and ready=0. Array entries already written keep their partial contents.
- start while busy is ignored.
- start and a key write in the same IDLE cycle: the write lands first, and generation uses the newly written key_reg value (PC-1 is taken in LOAD).
- key_we_hi and key_we_lo together: both halves take wdata.
- Re-start with the same key and a different mode regenerates the array and updates mode_q. The read order switches only when the new mode_q is latched.
- Reset values (asynchronous):
  - state = IDLE, ready = 0, busy = 0
  - key_reg = 0, C = D = 0, rnd = 0, mode_q = 0
  - all sk entries = 0, so subkey = 0

## Timing
- start sampled high at edge N in IDLE:
  - After edge N: LOAD, busy = 1.
  - After edge N+1: ROUND with rnd = 0.
  - Edges N+2 … N+17: write sk[0] … sk[15].
  - After edge N+17: IDLE, busy = 0, ready = 1.
- Total latency is 17 cycles from start to ready, and busy is high for exactly 17 cycles.
- sk[k] is readable in the cycle after edge N+2+k. The bus must nevertheless wait for ready.
- subkey has zero-cycle latency from sk_idx and mode_q; there is no output register.
- ready stays high until the next start or key write.
- Reset asserted mid-run forces every reset value immediately, with no clock edge needed. After reset deassertion the block sits in IDLE.

## Test plan
- Reset: assert reset mid-ROUND -> busy = 0, ready = 0, and subkey = 48'h0 for every sk_idx without a clock edge.
- Encrypt schedule:
  - Stimulus: write hi = 32'h13345779, lo = 32'h9BBCDFF1, start with mode = 0.
  - busy is high for exactly 17 cycles, then ready = 1.
  - sk_idx 0 -> 48'h1B02EFFC7072; sk_idx 1 -> 48'h79AED9DBC9E5; sk_idx 15 -> 48'hCB3D8B0E17F5.
- Decrypt order: same key, start with mode = 1 -> sk_idx 0 -> 48'hCB3D8B0E17F5, and sk_idx 15 -> 48'h1B02EFFC7072.
- Abort: key_we_lo pulse at edge N+8 of a run -> busy = 0 and ready = 0 after that edge. A fresh start then completes in 17 cycles with the new key.
- Ignored start: start pulses at edges N+3 and N+10 during a run -> ready still rises after edge N+17, and no second run follows.
- Same-cycle write and start:
  - Stimulus: from reset, write hi = 32'h13345779. Then in one IDLE cycle, assert key_we_lo with 32'h9BBCDFF1 together with start (mode = 0).
  - sk_idx 0 -> 48'h1B02EFFC7072.
  - A parity-bit-only key change (lo = 32'h9BBCDFF0) yields identical subkeys.
